// File: rtl/tile_obi_mem.sv
// tile_obi_mem: shared single-ported tile memory serving NUM_PORTS OBI masters.
// A round-robin arbiter issues at most one grant per cycle. Responses come back
// in grant order through a READ_LATENCY-deep pipeline.
// Optional feature: define TILE_OBI_MEM_BOUNDS_CHECK_EN to flag out-of-range
// accesses with err_o (writes dropped, reads return DEAD_BEEF). Without it,
// the word index wraps modulo DEPTH and err_o stays 0.
module tile_obi_mem #(
    parameter int unsigned       NUM_PORTS    = 2,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DEPTH        = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int unsigned       READ_LATENCY = 1
) (
    input  logic                          core_clk,
    input  logic                          arst_n,
    input  logic [NUM_PORTS-1:0]          req_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    input  logic [NUM_PORTS-1:0]          we_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] be_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]          rvalid_o,
    output logic [NUM_PORTS*DATA_W-1:0]   rdata_o,
    output logic [NUM_PORTS-1:0]          err_o
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LAT   = READ_LATENCY;

    logic [PTR_W-1:0]  rr_q;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  cand;
    logic              found;
    logic              grant;

    logic              sel_we;
    logic [BYTES-1:0]  sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  word_idx;
    logic              in_range;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;
    logic              unused_offset;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [LAT-1:0]    valid_q;
    logic [LAT-1:0]    err_q;
    logic [PTR_W-1:0]  port_q [LAT];
    logic [DATA_W-1:0] data_q [LAT];

    // Round-robin search starting at rr_q; no grant while reset is asserted
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            cand = PTR_W'((int'(rr_q) + i) % int'(NUM_PORTS));
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        grant = found & arst_n;
        gnt_o = '0;
        if (grant) begin
            gnt_o[winner] = 1'b1;
        end
    end

    // Route the winning port's request fields and decode the word address
    always_comb begin
        sel_we    = we_i[winner];
        sel_be    = be_i[int'(winner)*BYTES +: BYTES];
        sel_addr  = addr_i[int'(winner)*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[int'(winner)*DATA_W +: DATA_W];
        offset    = sel_addr - BASE_ADDR;
        word_idx  = IDX_W'(offset >> OFF_W);
`ifdef TILE_OBI_MEM_BOUNDS_CHECK_EN
        in_range  = (sel_addr >= BASE_ADDR) &&
                    (64'(offset) < 64'(DEPTH) * 64'(BYTES));
        resp_err  = ~in_range;
        if (sel_we) begin
            resp_data = '0;
        end else if (!in_range) begin
            resp_data = {(DATA_W/32){32'hDEAD_BEEF}};
        end else begin
            resp_data = mem[word_idx];
        end
`else
        in_range  = 1'b1;
        resp_err  = 1'b0;
        resp_data = sel_we ? '0 : mem[word_idx];
`endif
    end

    assign unused_offset = ^offset;

    // Arbiter pointer and response control pipeline; reset drops in-flight responses
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            rr_q    <= '0;
            valid_q <= '0;
            err_q   <= '0;
            for (int s = 0; s < int'(LAT); s++) begin
                port_q[s] <= '0;
            end
        end else begin
            if (grant) begin
                rr_q <= (int'(winner) == int'(NUM_PORTS) - 1) ? '0 : winner + 1'b1;
            end
            valid_q[0] <= grant;
            err_q[0]   <= grant & resp_err;
            port_q[0]  <= winner;
            for (int s = 1; s < int'(LAT); s++) begin
                valid_q[s] <= valid_q[s-1];
                err_q[s]   <= err_q[s-1];
                port_q[s]  <= port_q[s-1];
            end
        end
    end

    // Memory array and response data path; data is qualified by valid_q so it needs no reset
    always_ff @(posedge core_clk) begin
        if (grant && sel_we && in_range) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (sel_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
        data_q[0] <= resp_data;
        for (int s = 1; s < int'(LAT); s++) begin
            data_q[s] <= data_q[s-1];
        end
    end

    // Steer the last pipeline stage to the port that issued the request
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = '0;
        if (valid_q[LAT-1]) begin
            rvalid_o[port_q[LAT-1]]                          = 1'b1;
            rdata_o[int'(port_q[LAT-1])*DATA_W +: DATA_W]    = data_q[LAT-1];
            err_o[port_q[LAT-1]]                             = err_q[LAT-1];
        end
    end

endmodule

// File: tb/tb_tile_obi_mem.sv
// tb_tile_obi_mem: directed self-checking bench for tile_obi_mem with two
// ports, 32-bit data, 256 words at base 0x1000 and a three-stage response pipe.
// Bounds expectations follow TILE_OBI_MEM_BOUNDS_CHECK_EN when it is defined.
module tb_tile_obi_mem;

    localparam int          NP    = 2;
    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic             core_clk = 1'b0;
    logic             arst_n   = 1'b0;
    logic [NP-1:0]    req      = '0;
    logic [NP-1:0]    gnt;
    logic [NP-1:0]    we       = '0;
    logic [NP*4-1:0]  be       = '0;
    logic [NP*AW-1:0] addr     = '0;
    logic [NP*DW-1:0] wdata    = '0;
    logic [NP-1:0]    rvalid;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    err;

    int total = 0;
    int bad   = 0;

    tile_obi_mem #(
        .NUM_PORTS   (NP),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .READ_LATENCY(LAT)
    ) dut (
        .core_clk(core_clk),
        .arst_n  (arst_n),
        .req_i   (req),
        .gnt_o   (gnt),
        .we_i    (we),
        .be_i    (be),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .err_o   (err)
    );

    // Free-running clock
    always #5 core_clk = ~core_clk;

    // Abort if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic driveReq(input int p, input bit t_we, input logic [3:0] t_be,
                            input logic [31:0] t_addr, input logic [31:0] t_wdata);
        req[p]            = 1'b1;
        we[p]             = t_we;
        be[p*4 +: 4]      = t_be;
        addr[p*32 +: 32]  = t_addr;
        wdata[p*32 +: 32] = t_wdata;
    endtask

    task automatic clearReq(input int p);
        req[p]            = 1'b0;
        we[p]             = 1'b0;
        be[p*4 +: 4]      = '0;
        addr[p*32 +: 32]  = '0;
        wdata[p*32 +: 32] = '0;
    endtask

    // One isolated transaction: grant check, quiet pipeline, single response pulse
    task automatic applyStimulus(input int p, input bit t_we, input logic [3:0] t_be,
                                 input logic [31:0] t_addr, input logic [31:0] t_wdata,
                                 input logic [31:0] exp_rd, input bit exp_err, input string tag);
        @(negedge core_clk);
        driveReq(p, t_we, t_be, t_addr, t_wdata);
        #1;
        checkOutput({tag, ".gnt"}, 64'(gnt), 64'(1) << p);
        @(posedge core_clk);
        #1;
        clearReq(p);
        for (int k = 1; k < LAT; k++) begin
            @(negedge core_clk);
            checkOutput({tag, ".early"}, 64'(rvalid), 64'(0));
        end
        @(negedge core_clk);
        checkOutput({tag, ".rvalid"}, 64'(rvalid), 64'(1) << p);
        checkOutput({tag, ".rdata"}, rdata, 64'(exp_rd) << (p*32));
        checkOutput({tag, ".err"}, 64'(err), 64'(exp_err) << p);
        @(negedge core_clk);
        checkOutput({tag, ".pulse"}, 64'(rvalid), 64'(0));
    endtask

    logic [1:0] hist [16];
    logic [1:0] exp_g;
    logic [1:0] exp_rv;

    // Directed test sequence
    initial begin
        $display("[TB] start");

        // Outputs stay quiet during reset even with requests pending
        driveReq(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
        driveReq(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
        repeat (3) @(negedge core_clk);
        checkOutput("rst.gnt", 64'(gnt), 64'(0));
        checkOutput("rst.rvalid", 64'(rvalid), 64'(0));
        checkOutput("rst.rdata", rdata, 64'(0));
        checkOutput("rst.err", 64'(err), 64'(0));
        clearReq(0);
        clearReq(1);
        @(negedge core_clk);
        arst_n = 1'b1;

        // Basic write then read, plus ignored low address bits
        applyStimulus(0, 1'b1, 4'hF, BASE + 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, "wr10");
        applyStimulus(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, "rd10");
        applyStimulus(0, 1'b0, 4'hF, BASE + 32'h13, 32'h0, 32'hCAFE_F00D, 1'b0, "rd13");

        // Byte enables on port 1
        applyStimulus(1, 1'b1, 4'hF, BASE + 32'h20, 32'h1122_3344, 32'h0, 1'b0, "wr20a");
        applyStimulus(1, 1'b1, 4'b0101, BASE + 32'h20, 32'hAABB_CCDD, 32'h0, 1'b0, "wr20b");
        applyStimulus(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0, 32'h11BB_33DD, 1'b0, "rd20");

        // Read-after-write across ports in consecutive cycles
        @(negedge core_clk);
        driveReq(1, 1'b1, 4'hF, BASE + 32'h40, 32'h55);
        #1;
        checkOutput("raw.gnt1", 64'(gnt), 64'(2));
        @(posedge core_clk);
        #1;
        clearReq(1);
        driveReq(0, 1'b0, 4'hF, BASE + 32'h40, 32'h0);
        @(negedge core_clk);
        checkOutput("raw.gnt0", 64'(gnt), 64'(1));
        @(posedge core_clk);
        #1;
        clearReq(0);
        for (int j = 1; j <= LAT; j++) begin
            @(negedge core_clk);
            if (j == LAT - 1) begin
                checkOutput("raw.wresp", 64'(rvalid), 64'(2));
                checkOutput("raw.wdata", rdata, 64'(0));
            end else if (j == LAT) begin
                checkOutput("raw.rresp", 64'(rvalid), 64'(1));
                checkOutput("raw.rdata", rdata, 64'h55);
            end else begin
                checkOutput("raw.quiet", 64'(rvalid), 64'(0));
            end
        end

        // Bounds handling at BASE + DEPTH*4 (and below BASE when checked)
        applyStimulus(0, 1'b1, 4'hF, BASE, 32'h1234_5678, 32'h0, 1'b0, "wr0");
`ifdef TILE_OBI_MEM_BOUNDS_CHECK_EN
        applyStimulus(0, 1'b0, 4'hF, BASE + DEPTH*4, 32'h0, 32'hDEAD_BEEF, 1'b1, "oob.rd");
        applyStimulus(0, 1'b1, 4'hF, BASE + DEPTH*4, 32'hA5A5_A5A5, 32'h0, 1'b1, "oob.wr");
        applyStimulus(0, 1'b0, 4'hF, BASE, 32'h0, 32'h1234_5678, 1'b0, "oob.keep");
        applyStimulus(1, 1'b0, 4'hF, BASE - 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b1, "oob.low");
`else
        applyStimulus(0, 1'b0, 4'hF, BASE + DEPTH*4, 32'h0, 32'h1234_5678, 1'b0, "wrap.rd");
        applyStimulus(0, 1'b1, 4'hF, BASE + DEPTH*4, 32'hA5A5_A5A5, 32'h0, 1'b0, "wrap.wr");
        applyStimulus(0, 1'b0, 4'hF, BASE, 32'h0, 32'hA5A5_A5A5, 1'b0, "wrap.word0");
`endif

        // Contention from reset: grants alternate, responses follow grant order
        @(negedge core_clk);
        arst_n = 1'b0;
        driveReq(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
        driveReq(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
        #1;
        checkOutput("cont.rstgnt", 64'(gnt), 64'(0));
        @(negedge core_clk);
        arst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_g   = (c % 2 == 0) ? 2'b01 : 2'b10;
            hist[c] = exp_g;
            checkOutput($sformatf("cont.gnt%0d", c), 64'(gnt), 64'(exp_g));
            exp_rv = (c >= LAT) ? hist[c-LAT] : 2'b00;
            checkOutput($sformatf("cont.rv%0d", c), 64'(rvalid), 64'(exp_rv));
            if (exp_rv == 2'b01) begin
                checkOutput($sformatf("cont.rd%0d", c), rdata, 64'hCAFE_F00D);
            end else if (exp_rv == 2'b10) begin
                checkOutput($sformatf("cont.rd%0d", c), rdata, 64'h11BB_33DD << 32);
            end
            @(negedge core_clk);
        end
        clearReq(0);
        clearReq(1);
        repeat (LAT + 1) @(negedge core_clk);

        // Reset while responses are in flight; pointer must restart at port 0
        driveReq(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
        @(posedge core_clk);
        @(posedge core_clk);
        #2;
        arst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge core_clk);
            checkOutput("mid.gnt", 64'(gnt), 64'(0));
            checkOutput("mid.rvalid", 64'(rvalid), 64'(0));
        end
        driveReq(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
        arst_n = 1'b1;
        #1;
        checkOutput("mid.rrgnt", 64'(gnt), 64'(1));
        @(posedge core_clk);
        #1;
        clearReq(0);
        clearReq(1);
        for (int m = 0; m < LAT; m++) begin
            @(negedge core_clk);
            if (m == LAT - 1) begin
                checkOutput("mid.resp", 64'(rvalid), 64'(1));
                checkOutput("mid.rdata", rdata, 64'hCAFE_F00D);
            end else begin
                checkOutput("mid.stale", 64'(rvalid), 64'(0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_obi_mem.md
# tile_obi_mem

Shared tile-local memory with a parametrised number of OBI slave ports, built so that the instruction and data interfaces of each core in a tile (and optionally a debug or DMA master) can be served from one single-ported SRAM. A round-robin arbiter grants at most one request per cycle. Responses return in grant order through a fixed-latency pipeline. It sits between the core memory interfaces and the tile interconnect, and generalises the single-core tile to N masters with configurable width, depth and latency.

## Interface
- NUM_PORTS, 2, number of OBI master ports (1..8)
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 32, byte address width
- DEPTH, 4096, memory size in DATA_W words; power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- READ_LATENCY, 1, grant-to-rvalid cycles (1..4)

- core_clk  in  1  clock; all state updates on rising edge
- arst_n  in  1  asynchronous active-low reset
- req_i  in  NUM_PORTS  request per port
- gnt_o  out  NUM_PORTS  grant per port; combinational from req_i and arbiter state
- we_i  in  NUM_PORTS  1 = write
- be_i  in  NUM_PORTS*DATA_W/8  byte enables; port p at slice p
- addr_i  in  NUM_PORTS*ADDR_W  byte address
- wdata_i  in  NUM_PORTS*DATA_W  write data
- rvalid_o  out  NUM_PORTS  response valid; one-cycle pulse per granted request
- rdata_o  out  NUM_PORTS*DATA_W  read data, valid with rvalid_o
- err_o  out  NUM_PORTS  error flag, valid with rvalid_o

## Operation
- Arbiter: round-robin pointer rr_q, resets to 0. In a cycle the winner is the first port p with req_i[p]=1, searching from rr_q upward and wrapping modulo NUM_PORTS. gnt_o[winner]=1 and all other bits are 0. On the grant edge rr_q becomes (winner+1) mod NUM_PORTS. With no request, rr_q holds.
- While arst_n=0, gnt_o is all 0.
- Word index = (addr - BASE_ADDR) >> log2(DATA_W/8). The low address bits are ignored.
- Granted write: on the grant edge, each byte with be=1 is written. Bytes with be=0 are unchanged. The response carries rdata=0.
- Granted read: returns the word as it stands after all earlier grants. A write at cycle N followed by a read of the same word at N+1 returns the new data.
- Response pipeline: READ_LATENCY stages of {valid, port index, err, data}. The stage output drives rvalid_o/rdata_o/err_o of the recorded port only. rdata_o of all other ports is 0.
- Only one grant is issued per cycle, so there is never more than one response per cycle. No response is ever dropped or reordered.
- Memory contents are not reset.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, rr_q=0, all pipeline valid bits 0.
- A request granted at rising edge N produces rvalid at cycle N+READ_LATENCY, high for exactly one cycle.
- The master holds req/addr/we/be/wdata until the cycle in which gnt is seen (OBI). A back-to-back request on the same port may be granted in the next cycle.
- Full throughput: one transaction per cycle, sustained.
- Simultaneous requests from all ports are each served once per NUM_PORTS cycles.
- Reset asserted mid-operation clears the pipeline immediately. In-flight responses are lost. Writes already past their grant edge are kept.

## Configuration
- TILE_OBI_MEM_BOUNDS_CHECK_EN defined:
  - An address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) is granted normally.
  - A write to such an address is discarded.
  - A read of such an address returns {DATA_W/32 copies of 32'hDEAD_BEEF}.
  - The response for either case has err_o=1 at the same latency.
- TILE_OBI_MEM_BOUNDS_CHECK_EN undefined:
  - The word index wraps modulo DEPTH.
  - err_o is tied to 0.

## Test plan
- Reset and write/read: port 0 writes 32'hCAFE_F00D to 0x10 with be=4'hF, then reads 0x10. Required: gnt in the request cycle, rvalid after READ_LATENCY cycles, rdata=32'hCAFE_F00D, all outputs 0 during reset.
- Byte enables: write 32'h1122_3344 to 0x20, then write 32'hAABB_CCDD with be=4'b0101, then read. Required: rdata=32'h11BB_33DD.
- Contention: ports 0 and 1 request continuously from reset. Required: grants alternate 0,1,0,1, with exactly one gnt per cycle. Each rvalid pulse goes to the port granted READ_LATENCY cycles earlier.
- RAW across ports: port 1 writes 0x55 to 0x40 at cycle N and port 0 reads 0x40 at N+1. Required: port 0 sees rdata=0x55.
- Reset mid-burst: assert arst_n=0 while READ_LATENCY=3 responses are in flight. Required: no rvalid during reset or after release, and rr_q restarts at 0.
- Bounds: with the macro, a read of BASE_ADDR+DEPTH*4 returns 32'hDEAD_BEEF with err_o=1 and memory is unchanged. Without the macro, the same read returns word 0 with err_o=0.
